// File: rtl/cpu_mcyc_ctrl.sv
// Multicycle sequencer for the minisys-32 core: walks the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB with a bus-ready timeout, run/step control and a retire counter.
module cpu_mcyc_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_step,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_if_req,
    output logic             o_ir_we,
    output logic             o_dm_req,
    output logic             o_dm_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_src,
    output logic             o_reg_we,
    output logic [1:0]       o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_alu_src,
    output logic [1:0]       o_alu_op,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired,
    output logic             o_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    logic w_is_r, w_is_jr, w_is_j, w_is_jal, w_is_beq, w_is_bne;
    logic w_is_lw, w_is_sw, w_is_iarith, w_is_legal;
    logic w_br_taken, w_wait_expired, w_waiting;

    assign w_is_r      = (i_opcode == OP_RTYPE);
    assign w_is_jr     = w_is_r && (i_funct == FN_JR);
    assign w_is_j      = (i_opcode == OP_J);
    assign w_is_jal    = (i_opcode == OP_JAL);
    assign w_is_beq    = (i_opcode == OP_BEQ);
    assign w_is_bne    = (i_opcode == OP_BNE);
    assign w_is_lw     = (i_opcode == OP_LW);
    assign w_is_sw     = (i_opcode == OP_SW);
    assign w_is_iarith = (i_opcode[5:3] == 3'b001);
    assign w_is_legal  = w_is_r || w_is_beq || w_is_bne || w_is_lw || w_is_sw || w_is_iarith;
    assign w_br_taken  = (w_is_beq && i_zero) || (w_is_bne && !i_zero);

    // A bus request that has already waited TIMEOUT-1 cycles gives up on the next miss.
    assign w_waiting      = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready;
    assign w_wait_expired = w_waiting && ((r_wait + 8'd1) == TIMEOUT_C);

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        o_if_req     = 1'b0;
        o_ir_we      = 1'b0;
        o_dm_req     = 1'b0;
        o_dm_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_pc_src     = 2'd0;
        o_reg_we     = 1'b0;
        o_reg_dst    = 2'd0;
        o_mem_to_reg = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (i_run || i_step)
                    w_state_next = S_FETCH;
            end
            S_FETCH: begin
                o_if_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_we      = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_wait_expired) begin
                    w_state_next = S_ERR;
                end
            end
            S_DECODE: begin
                if (w_is_j || w_is_jal) begin
                    o_pc_we  = 1'b1;
                    o_pc_src = 2'd2;
                    w_retire = 1'b1;
                    if (w_is_jal) begin
                        o_reg_we  = 1'b1;
                        o_reg_dst = 2'd2;
                    end
                end else if (w_is_legal) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_state_next = S_ERR;
                end
            end
            S_EXEC: begin
                if (w_is_r) begin
                    o_alu_op = 2'b10;
                    if (w_is_jr) begin
                        o_pc_we  = 1'b1;
                        o_pc_src = 2'd3;
                        w_retire = 1'b1;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_is_iarith) begin
                    o_alu_op     = 2'b11;
                    o_alu_src    = 1'b1;
                    w_state_next = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    o_alu_op     = 2'b00;
                    o_alu_src    = 1'b1;
                    w_state_next = S_MEM;
                end else if (w_is_beq || w_is_bne) begin
                    o_alu_op = 2'b01;
                    o_pc_we  = 1'b1;
                    o_pc_src = w_br_taken ? 2'd1 : 2'd0;
                    w_retire = 1'b1;
                end else begin
                    // Opcode changed under us after DECODE; treat as illegal.
                    w_state_next = S_ERR;
                end
            end
            S_MEM: begin
                o_dm_req = 1'b1;
                o_dm_we  = w_is_sw;
                if (i_mem_ready) begin
                    if (w_is_sw) begin
                        o_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_wait_expired) begin
                    w_state_next = S_ERR;
                end
            end
            S_WB: begin
                o_reg_we     = 1'b1;
                o_pc_we      = 1'b1;
                o_reg_dst    = w_is_r ? 2'd1 : 2'd0;
                o_mem_to_reg = w_is_lw;
                w_retire     = 1'b1;
            end
            S_ERR: begin
                w_state_next = S_ERR;
            end
            default: begin
                w_state_next = S_ERR;
            end
        endcase
        if (w_retire)
            w_state_next = i_run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_wait    <= 8'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state)
                r_wait <= 8'd0;
            else if (w_waiting)
                r_wait <= r_wait + 8'd1;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign o_state   = r_state;
    assign o_retired = r_retired;
    assign o_err     = (r_state == S_ERR);

endmodule

// File: tb/tb_cpu_mcyc_ctrl.sv
// Bench for cpu_mcyc_ctrl: directed and random instructions, each expanded into its
// expected per-cycle control trace from the instruction class and chosen wait states.
module tb_cpu_mcyc_ctrl;

    localparam int TO = 15;
    localparam int CW = 4;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;

    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, step = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;

    logic o_if_req, o_ir_we, o_dm_req, o_dm_we, o_pc_we, o_reg_we, o_mem_to_reg, o_alu_src, o_err;
    logic [1:0] o_pc_src, o_reg_dst, o_alu_op;
    logic [2:0] o_state;
    logic [CW-1:0] o_retired;

    int n_tests = 0;
    int n_fail  = 0;
    int m_retired = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       if_req, ir_we, dm_req, dm_we, pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       m2r, alu_src;
        logic [1:0] alu_op;
    } vec_t;

    cpu_mcyc_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step),
        .i_opcode(opcode), .i_funct(funct), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_if_req(o_if_req), .o_ir_we(o_ir_we), .o_dm_req(o_dm_req), .o_dm_we(o_dm_we),
        .o_pc_we(o_pc_we), .o_pc_src(o_pc_src), .o_reg_we(o_reg_we), .o_reg_dst(o_reg_dst),
        .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_alu_op(o_alu_op),
        .o_state(o_state), .o_retired(o_retired), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t at(input logic [2:0] st);
        vec_t v = '0;
        v.st = st;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_now(input string tag, input vec_t e);
        vec_t o;
        o.st = o_state; o.if_req = o_if_req; o.ir_we = o_ir_we; o.dm_req = o_dm_req;
        o.dm_we = o_dm_we; o.pc_we = o_pc_we; o.pc_src = o_pc_src; o.reg_we = o_reg_we;
        o.reg_dst = o_reg_dst; o.m2r = o_mem_to_reg; o.alu_src = o_alu_src; o.alu_op = o_alu_op;
        chk({tag, "/ctl"}, 32'(o), 32'(e));
        chk({tag, "/retired"}, 32'(o_retired), 32'(m_retired % (1 << CW)));
        chk({tag, "/err"}, 32'(o_err), 32'(e.st == 3'd7));
    endtask

    // Entered just after a rising edge; drives ready, checks mid-cycle, advances one clock.
    task automatic cyc(input string tag, input vec_t e, input logic rdy);
        mem_ready = rdy;
        if (e.st != 3'd0)
            step = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_now(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input string tag, input logic s);
        step = s;
        cyc(tag, at(3'd0), 1'($urandom_range(0, 1)));
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int fw, input int mw, input logic drop_run);
        vec_t e;
        logic legal;
        opcode = op; funct = fn; zero = z;
        legal = (op == OP_R) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_LW) ||
                (op == OP_SW) || (op[5:3] == 3'b001);
        for (int i = 0; i < fw; i++) begin
            e = at(3'd1); e.if_req = 1'b1;
            cyc({tag, "/fw"}, e, 1'b0);
        end
        e = at(3'd1); e.if_req = 1'b1; e.ir_we = 1'b1;
        cyc({tag, "/f"}, e, 1'b1);
        if (drop_run) run = 1'b0;
        e = at(3'd2);
        if (op == OP_J || op == OP_JAL) begin
            e.pc_we = 1'b1; e.pc_src = 2'd2;
            if (op == OP_JAL) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; end
            cyc({tag, "/d"}, e, 1'($urandom_range(0, 1)));
            m_retired++;
            return;
        end
        cyc({tag, "/d"}, e, 1'($urandom_range(0, 1)));
        if (!legal) return;
        e = at(3'd3);
        if (op == OP_BEQ || op == OP_BNE) begin
            e.alu_op = 2'b01; e.pc_we = 1'b1;
            e.pc_src = (((op == OP_BEQ) && z) || ((op == OP_BNE) && !z)) ? 2'd1 : 2'd0;
            cyc({tag, "/x"}, e, 1'($urandom_range(0, 1)));
            m_retired++;
            return;
        end
        if (op == OP_R) begin
            e.alu_op = 2'b10;
            if (fn == 6'b001000) begin
                e.pc_we = 1'b1; e.pc_src = 2'd3;
                cyc({tag, "/x"}, e, 1'($urandom_range(0, 1)));
                m_retired++;
                return;
            end
        end else if (op == OP_LW || op == OP_SW) begin
            e.alu_op = 2'b00; e.alu_src = 1'b1;
        end else begin
            e.alu_op = 2'b11; e.alu_src = 1'b1;
        end
        cyc({tag, "/x"}, e, 1'($urandom_range(0, 1)));
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i < mw; i++) begin
                e = at(3'd4); e.dm_req = 1'b1; e.dm_we = (op == OP_SW);
                cyc({tag, "/mw"}, e, 1'b0);
            end
            e = at(3'd4); e.dm_req = 1'b1; e.dm_we = (op == OP_SW); e.pc_we = (op == OP_SW);
            cyc({tag, "/m"}, e, 1'b1);
            if (op == OP_SW) begin
                m_retired++;
                return;
            end
        end
        e = at(3'd5); e.reg_we = 1'b1; e.pc_we = 1'b1;
        e.reg_dst = (op == OP_R) ? 2'd1 : 2'd0;
        e.m2r = (op == OP_LW);
        cyc({tag, "/wb"}, e, 1'($urandom_range(0, 1)));
        m_retired++;
    endtask

    task automatic do_reset(input string tag);
        run = 1'b0; step = 1'b0;
        rst_n = 1'b0;
        m_retired = 0;
        #1;
        chk_now(tag, at(3'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] op, fn;
        vec_t e;
        ops = '{OP_R, OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, 6'd8, 6'd13};

        // Reset state, then idle with run and step low
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", at(3'd0), 1'b1);
        rst_n = 1'b1;
        idle_cyc("idle0", 1'b0);
        idle_cyc("idle1", 1'b0);

        // Free-run through directed instruction classes
        run = 1'b1;
        idle_cyc("start", 1'b0);
        instr("add", OP_R, 6'b100000, 1'b0, 0, 0, 1'b0);
        instr("lw_w3", OP_LW, 6'd0, 1'b0, 0, 3, 1'b0);
        instr("beq_z1", OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b0);
        instr("bne_z1", OP_BNE, 6'd0, 1'b1, 0, 0, 1'b0);
        instr("bne_z0", OP_BNE, 6'd0, 1'b0, 1, 0, 1'b0);
        instr("sw_w14", OP_SW, 6'd0, 1'b0, 0, TO - 1, 1'b0);
        instr("lw_w10_10", OP_LW, 6'd0, 1'b0, 10, 10, 1'b0);
        instr("addi", 6'b001000, 6'd0, 1'b0, 2, 0, 1'b0);
        instr("jr", OP_R, 6'b001000, 1'b0, 0, 0, 1'b0);
        instr("j", OP_J, 6'd0, 1'b0, 0, 0, 1'b0);

        // Randomized instruction stream; retired wraps with a 4-bit counter
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == 6'd8) op = 6'($urandom_range(8, 15));
            fn = 6'($urandom_range(0, 63));
            if (op == OP_R && $urandom_range(0, 3) == 0) fn = 6'b001000;
            instr("rnd", op, fn, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
        end

        // Run dropped mid-instruction: finishes, then parks in IDLE
        instr("drop_run", OP_LW, 6'd0, 1'b0, 1, 2, 1'b1);
        idle_cyc("parked", 1'b0);
        idle_cyc("parked2", 1'b0);

        // Single step a jal
        idle_cyc("step", 1'b1);
        instr("step_jal", OP_JAL, 6'd0, 1'b0, 0, 0, 1'b0);
        idle_cyc("after_step", 1'b0);
        idle_cyc("after_step2", 1'b0);

        // Asynchronous reset in EXEC of a lw
        run = 1'b1;
        idle_cyc("pre_rst", 1'b0);
        opcode = OP_LW;
        e = at(3'd1); e.if_req = 1'b1; e.ir_we = 1'b1;
        cyc("rst_f", e, 1'b1);
        cyc("rst_d", at(3'd2), 1'b0);
        mem_ready = 1'b1;
        do_reset("mid_rst");
        idle_cyc("post_rst", 1'b0);

        // Fetch timeout then sticky ERR, step ignored
        run = 1'b1;
        idle_cyc("to_start", 1'b0);
        for (int i = 0; i < TO; i++) begin
            e = at(3'd1); e.if_req = 1'b1;
            cyc("to_fetch", e, 1'b0);
        end
        for (int i = 0; i < 4; i++) cyc("err_hold", at(3'd7), 1'b1);

        // Illegal opcode from DECODE
        do_reset("rst2");
        run = 1'b1;
        idle_cyc("ill_start", 1'b0);
        instr("illegal", 6'b111111, 6'd0, 1'b0, 0, 0, 1'b0);
        cyc("ill_err", at(3'd7), 1'b1);
        cyc("ill_err2", at(3'd7), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
